// File: rtl/chimera_cluster_quiesce_if.sv
// chimera_cluster_quiesce_if
// Bundle of NumPorts independent AXI links carrying the handshake bits the
// quiesce unit gates or observes, plus an opaque per-port request/response
// payload that passes straight through.
//   master modport : drives AW/W/AR valids, W last, B/R readies, request payload
//   slave modport  : drives AW/W/AR readies, B/R valids, R last, response payload
interface chimera_cluster_quiesce_if #(
  parameter int  NumPorts = 3,
  parameter type req_t    = logic,
  parameter type resp_t   = logic
);
  logic [NumPorts-1:0] aw_valid, aw_ready;
  logic [NumPorts-1:0] w_valid, w_ready, w_last;
  logic [NumPorts-1:0] b_valid, b_ready;
  logic [NumPorts-1:0] ar_valid, ar_ready;
  logic [NumPorts-1:0] r_valid, r_ready, r_last;
  req_t                req_pld  [NumPorts];
  resp_t               resp_pld [NumPorts];

  modport master (
    output aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready, req_pld,
    input  aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last, resp_pld
  );

  modport slave (
    input  aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready, req_pld,
    output aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last, resp_pld
  );
endinterface

// File: rtl/chimera_cluster_quiesce.sv
// chimera_cluster_quiesce
// Per-cluster AXI quiesce/isolation unit. Counts outstanding write, read and
// W bursts on each link, caps them at MaxTxn, and on isolate_i stops new
// AW/AR, lets in-flight traffic drain, then reports the cluster isolated.
// All channels are combinational pass-through; only AW/AR valid/ready are gated.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   isolate_i     : level request to quiesce all links
//   isolated_o    : high while every link is drained and blocked
//   busy_o        : per link, any outstanding read, write or W burst
//   slv           : cluster-side links (this unit is the slave)
//   mst           : interconnect-side links (this unit is the master)
module chimera_cluster_quiesce #(
  parameter int  NumPorts = 3,
  parameter int  MaxTxn   = 8,
  parameter type req_t    = logic,
  parameter type resp_t   = logic
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      isolate_i,
  output logic                      isolated_o,
  output logic [NumPorts-1:0]       busy_o,
  chimera_cluster_quiesce_if.slave  slv,
  chimera_cluster_quiesce_if.master mst
);

  localparam int CntW = $clog2(MaxTxn + 1);
  localparam logic [CntW-1:0] CapVal = CntW'(MaxTxn);

  typedef enum logic [1:0] {RUN, DRAIN, ISOLATED} state_e;

  state_e state_q, state_d;
  logic   admit;

  logic [CntW-1:0]     wr_cnt_q [NumPorts];
  logic [CntW-1:0]     rd_cnt_q [NumPorts];
  logic [CntW-1:0]     w_cnt_q  [NumPorts];
  logic [NumPorts-1:0] aw_lock_q, ar_lock_q;

  logic [NumPorts-1:0] aw_pass, ar_pass, aw_hs, ar_hs, aw_stall, ar_stall;
  logic [NumPorts-1:0] b_hs, r_done, w_done, busy;
  logic                all_idle;

  // Saturating up/down count; simultaneous inc and dec cancel.
  function automatic logic [CntW-1:0] cnt_next(input logic [CntW-1:0] cnt,
                                               input logic inc, input logic dec);
    if (inc && !dec && cnt != CapVal) return cnt + CntW'(1);
    if (dec && !inc && cnt != '0)     return cnt - CntW'(1);
    return cnt;
  endfunction

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RUN;
    else         state_q <= state_d;
  end

  // FSM next state; leaving DRAIN on a dropped request wins over isolating
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (isolate_i) state_d = DRAIN;
      DRAIN:    if (!isolate_i) state_d = RUN;
                else if (all_idle) state_d = ISOLATED;
      ISOLATED: if (!isolate_i) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    isolated_o = (state_q == ISOLATED);
    admit      = (state_q == RUN);
  end

  // A locked channel already showed valid downstream, so it must stay open
  // until it handshakes even if the cap or a quiesce would otherwise block it.
  always_comb begin
    aw_pass  = '0;
    ar_pass  = '0;
    aw_hs    = '0;
    ar_hs    = '0;
    aw_stall = '0;
    ar_stall = '0;
    busy     = '0;
    all_idle = 1'b1;
    for (int p = 0; p < NumPorts; p++) begin
      aw_pass[p]  = aw_lock_q[p] |
                    (admit & (wr_cnt_q[p] < CapVal) & (w_cnt_q[p] < CapVal));
      ar_pass[p]  = ar_lock_q[p] | (admit & (rd_cnt_q[p] < CapVal));
      aw_hs[p]    = slv.aw_valid[p] & mst.aw_ready[p] & aw_pass[p];
      ar_hs[p]    = slv.ar_valid[p] & mst.ar_ready[p] & ar_pass[p];
      aw_stall[p] = slv.aw_valid[p] & ~mst.aw_ready[p] & aw_pass[p];
      ar_stall[p] = slv.ar_valid[p] & ~mst.ar_ready[p] & ar_pass[p];
      busy[p]     = (wr_cnt_q[p] | rd_cnt_q[p] | w_cnt_q[p]) != '0;
      if (busy[p] || aw_lock_q[p] || ar_lock_q[p]) all_idle = 1'b0;
    end
    b_hs   = mst.b_valid & slv.b_ready;
    r_done = mst.r_valid & slv.r_ready & mst.r_last;
    w_done = slv.w_valid & mst.w_ready & slv.w_last;
    busy_o = busy;
  end

  // Link pass-through with AW/AR gating
  always_comb begin
    mst.aw_valid = slv.aw_valid & aw_pass;
    slv.aw_ready = mst.aw_ready & aw_pass;
    mst.ar_valid = slv.ar_valid & ar_pass;
    slv.ar_ready = mst.ar_ready & ar_pass;
    mst.w_valid  = slv.w_valid;
    mst.w_last   = slv.w_last;
    slv.w_ready  = mst.w_ready;
    slv.b_valid  = mst.b_valid;
    mst.b_ready  = slv.b_ready;
    slv.r_valid  = mst.r_valid;
    slv.r_last   = mst.r_last;
    mst.r_ready  = slv.r_ready;
    for (int p = 0; p < NumPorts; p++) begin
      mst.req_pld[p]  = req_t'(slv.req_pld[p]);
      slv.resp_pld[p] = resp_t'(mst.resp_pld[p]);
    end
  end

  // Outstanding counters and valid-stability locks
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < NumPorts; p++) begin
        wr_cnt_q[p] <= '0;
        rd_cnt_q[p] <= '0;
        w_cnt_q[p]  <= '0;
      end
      aw_lock_q <= '0;
      ar_lock_q <= '0;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        wr_cnt_q[p] <= cnt_next(wr_cnt_q[p], aw_hs[p], b_hs[p]);
        rd_cnt_q[p] <= cnt_next(rd_cnt_q[p], ar_hs[p], r_done[p]);
        w_cnt_q[p]  <= cnt_next(w_cnt_q[p],  aw_hs[p], w_done[p]);
        if (aw_hs[p])         aw_lock_q[p] <= 1'b0;
        else if (aw_stall[p]) aw_lock_q[p] <= 1'b1;
        if (ar_hs[p])         ar_lock_q[p] <= 1'b0;
        else if (ar_stall[p]) ar_lock_q[p] <= 1'b1;
      end
    end
  end

  // A response with nothing outstanding means the counters lost track.
  for (genvar p = 0; p < NumPorts; p++) begin : g_chk
    a_b_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(b_hs[p] && !aw_hs[p] && wr_cnt_q[p] == '0));
    a_r_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(r_done[p] && !ar_hs[p] && rd_cnt_q[p] == '0));
    a_w_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(w_done[p] && !aw_hs[p] && w_cnt_q[p] == '0));
  end

endmodule

// File: tb/tb_chimera_cluster_quiesce.sv
// tb_chimera_cluster_quiesce
// Directed bench for chimera_cluster_quiesce: a table of per-cycle vectors for
// the idle isolate/release sequence, then hand-written multi-cycle sequences
// for drain, valid locking, counter corner cases and the outstanding cap
// (second instance with MaxTxn=2).
module tb_chimera_cluster_quiesce;

  typedef logic [7:0] pld_t;

  logic clk = 1'b0;
  logic rst_n;
  logic isolate;
  logic isolated_a, isolated_b;
  logic [2:0] busy_a, busy_b;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  chimera_cluster_quiesce_if #(.NumPorts(3), .req_t(pld_t), .resp_t(pld_t)) slv_a ();
  chimera_cluster_quiesce_if #(.NumPorts(3), .req_t(pld_t), .resp_t(pld_t)) mst_a ();
  chimera_cluster_quiesce_if #(.NumPorts(3), .req_t(pld_t), .resp_t(pld_t)) slv_b ();
  chimera_cluster_quiesce_if #(.NumPorts(3), .req_t(pld_t), .resp_t(pld_t)) mst_b ();

  chimera_cluster_quiesce #(.NumPorts(3), .MaxTxn(8), .req_t(pld_t), .resp_t(pld_t)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .isolate_i(isolate), .isolated_o(isolated_a),
    .busy_o(busy_a), .slv(slv_a), .mst(mst_a)
  );

  chimera_cluster_quiesce #(.NumPorts(3), .MaxTxn(2), .req_t(pld_t), .resp_t(pld_t)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .isolate_i(isolate), .isolated_o(isolated_b),
    .busy_o(busy_b), .slv(slv_b), .mst(mst_b)
  );

  typedef struct packed {
    logic iso, awv, awr, wv, bv;
    logic e_iso, e_awv, e_awr, e_busy;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input pld_t act, input pld_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    slv_a.aw_valid = '0; slv_a.w_valid = '0; slv_a.w_last = '0;
    slv_a.ar_valid = '0; slv_a.b_ready = '1; slv_a.r_ready = '1;
    mst_a.aw_ready = '1; mst_a.w_ready = '1; mst_a.ar_ready = '1;
    mst_a.b_valid = '0; mst_a.r_valid = '0; mst_a.r_last = '0;
    slv_b.aw_valid = '0; slv_b.w_valid = '0; slv_b.w_last = '0;
    slv_b.ar_valid = '0; slv_b.b_ready = '1; slv_b.r_ready = '1;
    mst_b.aw_ready = '1; mst_b.w_ready = '1; mst_b.ar_ready = '1;
    mst_b.b_valid = '0; mst_b.r_valid = '0; mst_b.r_last = '0;
  endtask

  initial begin
    // Idle isolate/release, port 0 of instance A
    //           iso awv awr wv bv | e_iso e_awv e_awr e_busy
    tbl[0] = 9'b1_0_1_0_0__0_0_1_0;
    tbl[1] = 9'b1_0_1_0_0__0_0_0_0;
    tbl[2] = 9'b1_0_1_0_0__1_0_0_0;
    tbl[3] = 9'b1_1_1_0_0__1_0_0_0;
    tbl[4] = 9'b1_1_1_0_0__1_0_0_0;
    tbl[5] = 9'b0_1_1_0_0__1_0_0_0;
    tbl[6] = 9'b0_1_1_0_0__0_1_1_0;
    tbl[7] = 9'b0_0_1_1_0__0_0_1_1;
    tbl[8] = 9'b0_0_1_0_1__0_0_1_1;
    tbl[9] = 9'b0_0_1_0_0__0_0_1_0;

    rst_n = 1'b0;
    isolate = 1'b0;
    drive_idle();
    for (int p = 0; p < 3; p++) begin
      slv_a.req_pld[p] = '0; mst_a.resp_pld[p] = '0;
      slv_b.req_pld[p] = '0; mst_b.resp_pld[p] = '0;
    end

    // Reset state and pass-through while in reset
    slv_a.aw_valid[0] = 1'b1;
    slv_a.req_pld[0] = 8'hA5;
    mst_a.resp_pld[0] = 8'h3C;
    #3;
    chk("rst_isolated_a", isolated_a, 1'b0);
    chk("rst_isolated_b", isolated_b, 1'b0);
    chk("rst_busy_a", busy_a != 3'b000, 1'b0);
    chk("rst_busy_b", busy_b != 3'b000, 1'b0);
    chk("rst_aw_valid_pass", mst_a.aw_valid[0], 1'b1);
    chk("rst_aw_ready_pass", slv_a.aw_ready[0], 1'b1);
    chk8("req_payload", mst_a.req_pld[0], 8'hA5);
    chk8("resp_payload", slv_a.resp_pld[0], 8'h3C);
    slv_a.aw_valid[0] = 1'b0;
    #9 rst_n = 1'b1;

    // Table-driven idle isolate/release
    for (int i = 0; i < 10; i++) begin
      tick();
      isolate           = tbl[i].iso;
      slv_a.aw_valid[0] = tbl[i].awv;
      mst_a.aw_ready[0] = tbl[i].awr;
      slv_a.w_valid[0]  = tbl[i].wv;
      slv_a.w_last[0]   = tbl[i].wv;
      mst_a.b_valid[0]  = tbl[i].bv;
      #1;
      chk($sformatf("tbl%0d_isolated", i), isolated_a, tbl[i].e_iso);
      chk($sformatf("tbl%0d_mst_aw_valid", i), mst_a.aw_valid[0], tbl[i].e_awv);
      chk($sformatf("tbl%0d_slv_aw_ready", i), slv_a.aw_ready[0], tbl[i].e_awr);
      chk($sformatf("tbl%0d_busy0", i), busy_a[0], tbl[i].e_busy);
    end
    drive_idle();

    // Drain of three 4-beat reads on port 1
    for (int k = 0; k < 3; k++) begin
      tick();
      slv_a.ar_valid[1] = 1'b1;
      #1;
      chk("ar_accept_p1", slv_a.ar_ready[1], 1'b1);
    end
    tick();
    slv_a.ar_valid[1] = 1'b0;
    isolate = 1'b1;
    #1;
    chk("rd_busy_p1", busy_a[1], 1'b1);
    chk("rd_iso_before", isolated_a, 1'b0);
    tick();
    slv_a.ar_valid[0] = 1'b1;
    #1;
    chk("drain_ar_valid_p0", mst_a.ar_valid[0], 1'b0);
    chk("drain_ar_ready_p0", slv_a.ar_ready[0], 1'b0);
    slv_a.ar_valid[0] = 1'b0;
    for (int b = 1; b <= 12; b++) begin
      tick();
      mst_a.r_valid[1] = 1'b1;
      mst_a.r_last[1]  = (b % 4 == 0);
      #1;
      chk($sformatf("rd_drain_beat%0d_iso", b), isolated_a, 1'b0);
    end
    tick();
    mst_a.r_valid[1] = 1'b0;
    mst_a.r_last[1]  = 1'b0;
    #1;
    chk("rd_drain_iso_plus1", isolated_a, 1'b0);
    chk("rd_drain_busy_p1", busy_a[1], 1'b0);
    tick();
    chk("rd_drain_iso_plus2", isolated_a, 1'b1);
    isolate = 1'b0;
    tick();
    chk("rd_release_iso", isolated_a, 1'b0);

    // Locked AW survives an isolate request and completes
    tick();
    slv_a.aw_valid[0] = 1'b1;
    mst_a.aw_ready[0] = 1'b0;
    #1;
    chk("lock_aw_valid_run", mst_a.aw_valid[0], 1'b1);
    tick();
    isolate = 1'b1;
    #1;
    chk("lock_aw_valid_iso", mst_a.aw_valid[0], 1'b1);
    tick();
    chk("lock_aw_valid_drain", mst_a.aw_valid[0], 1'b1);
    chk("lock_iso_drain", isolated_a, 1'b0);
    tick();
    mst_a.aw_ready[0] = 1'b1;
    #1;
    chk("lock_aw_ready_hs", slv_a.aw_ready[0], 1'b1);
    tick();
    slv_a.aw_valid[0] = 1'b0;
    slv_a.w_valid[0]  = 1'b1;
    slv_a.w_last[0]   = 1'b1;
    #1;
    chk("lock_busy_w", busy_a[0], 1'b1);
    chk("lock_iso_w", isolated_a, 1'b0);
    tick();
    slv_a.w_valid[0] = 1'b0;
    slv_a.w_last[0]  = 1'b0;
    mst_a.b_valid[0] = 1'b1;
    #1;
    chk("lock_iso_b", isolated_a, 1'b0);
    tick();
    mst_a.b_valid[0] = 1'b0;
    #1;
    chk("lock_iso_after_b", isolated_a, 1'b0);
    chk("lock_busy_after_b", busy_a[0], 1'b0);
    tick();
    chk("lock_isolated", isolated_a, 1'b1);
    isolate = 1'b0;
    tick();
    tick();

    // Same-cycle AR handshake and R last on port 2
    tick();
    slv_a.ar_valid[2] = 1'b1;
    #1;
    chk("p2_ar_accept", slv_a.ar_ready[2], 1'b1);
    tick();
    mst_a.r_valid[2] = 1'b1;
    mst_a.r_last[2]  = 1'b1;
    #1;
    chk("p2_busy_before", busy_a[2], 1'b1);
    tick();
    slv_a.ar_valid[2] = 1'b0;
    #1;
    chk("p2_busy_after_both", busy_a[2], 1'b1);
    tick();
    mst_a.r_valid[2] = 1'b0;
    mst_a.r_last[2]  = 1'b0;
    #1;
    chk("p2_busy_after_last", busy_a[2], 1'b0);

    // Isolate withdrawn during DRAIN with writes outstanding
    tick();
    slv_a.aw_valid[0] = 1'b1;
    #1;
    chk("tog_aw1_ready", slv_a.aw_ready[0], 1'b1);
    tick();
    slv_a.aw_valid[0] = 1'b0;
    isolate = 1'b1;
    #1;
    chk("tog_iso_run", isolated_a, 1'b0);
    tick();
    isolate = 1'b0;
    slv_a.aw_valid[0] = 1'b1;
    #1;
    chk("tog_drain_blocks_aw", mst_a.aw_valid[0], 1'b0);
    chk("tog_iso_drain", isolated_a, 1'b0);
    tick();
    chk("tog_run_aw_valid", mst_a.aw_valid[0], 1'b1);
    chk("tog_run_aw_ready", slv_a.aw_ready[0], 1'b1);
    chk("tog_iso_back_run", isolated_a, 1'b0);
    tick();
    slv_a.aw_valid[0] = 1'b0;
    slv_a.w_valid[0]  = 1'b1;
    slv_a.w_last[0]   = 1'b1;
    #1;
    chk("tog_busy", busy_a[0], 1'b1);
    tick();
    tick();
    slv_a.w_valid[0] = 1'b0;
    slv_a.w_last[0]  = 1'b0;
    mst_a.b_valid[0] = 1'b1;
    tick();
    tick();
    mst_a.b_valid[0] = 1'b0;
    #1;
    chk("tog_busy_done", busy_a[0], 1'b0);
    chk("tog_iso_never", isolated_a, 1'b0);

    // Outstanding cap, MaxTxn=2, port 0 of instance B
    tick();
    slv_b.aw_valid[0] = 1'b1;
    #1;
    chk("cap_aw1_ready", slv_b.aw_ready[0], 1'b1);
    tick();
    chk("cap_aw2_ready", slv_b.aw_ready[0], 1'b1);
    tick();
    slv_b.aw_valid[0] = 1'b0;
    slv_b.w_valid[0]  = 1'b1;
    slv_b.w_last[0]   = 1'b0;
    tick();
    slv_b.w_last[0] = 1'b1;
    tick();
    slv_b.w_last[0] = 1'b0;
    tick();
    slv_b.w_last[0] = 1'b1;
    tick();
    slv_b.w_valid[0]  = 1'b0;
    slv_b.w_last[0]   = 1'b0;
    slv_b.aw_valid[0] = 1'b1;
    #1;
    chk("cap_aw3_blocked", mst_b.aw_valid[0], 1'b0);
    chk("cap_busy", busy_b[0], 1'b1);
    tick();
    mst_b.b_valid[0] = 1'b1;
    #1;
    chk("cap_aw3_blocked_b", mst_b.aw_valid[0], 1'b0);
    tick();
    mst_b.b_valid[0] = 1'b0;
    #1;
    chk("cap_aw3_pass_valid", mst_b.aw_valid[0], 1'b1);
    chk("cap_aw3_pass_ready", slv_b.aw_ready[0], 1'b1);
    tick();
    chk("cap_aw4_blocked", mst_b.aw_valid[0], 1'b0);
    slv_b.aw_valid[0] = 1'b0;

    // Reset mid-operation clears counters at once
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy_b", busy_b[0], 1'b0);
    chk("midrst_isolated_b", isolated_b, 1'b0);
    #3 rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
